round_judge: RTL and testbench

Sequential hit-judging and game-termination controller for the whack-a-mole top level. It sits between the light controller (lit position, on-window) and the keypad controller (decoded key pulses). For each light it decides hit or miss, and keeps score, miss, round and lives counters. It raises `game_over` according to the game mode latched at game start. It replaces the combinational hit-recording logic in the top level with a registered, one-decision-per-light scheme.

---
 rtl/round_judge.sv | 152 +++++++++++++++
 tb/tb_round_judge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/round_judge.sv
// rtl/round_judge.sv - registered hit/miss judge, score keeping and game-over control
module round_judge #(
  parameter int MAX_LIVES = 3,
  parameter int CW        = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    mode,
  input  logic [CW-1:0] max_hits,
  input  logic [5:0]    time_left,
  input  logic          light_valid,
  input  logic [3:0]    light_pos,
  input  logic          key_valid,
  input  logic [3:0]    key,
  output logic [CW-1:0] score,
  output logic [CW-1:0] misses,
  output logic [CW-1:0] rounds,
  output logic [1:0]    lives_left,
  output logic          hit_pulse,
  output logic          miss_pulse,
  output logic          game_over
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LIGHT, S_ARMED, S_HIT, S_MISSED, S_OVER
  } state_t;

  state_t        r_state;
  logic [3:0]    r_mode;
  logic [3:0]    r_target;
  logic          r_light_prev;
  logic [CW-1:0] r_score;
  logic [CW-1:0] r_misses;
  logic [CW-1:0] r_rounds;
  logic [1:0]    r_lives;
  logic          r_hit_pulse;
  logic          r_miss_pulse;
  logic          r_game_over;

  logic          w_lives_mode;
  logic          w_timed_mode;
  logic          w_cont_mode;
  logic          w_rounds_mode;
  logic          w_light_rise;
  logic          w_time_up;
  logic          w_end;
  logic [CW-1:0] w_score_inc;
  logic [CW-1:0] w_misses_inc;
  logic [CW-1:0] w_rounds_inc;
  logic [1:0]    w_lives_dec;

  // Unrecognised mode encodings fall through to normal play.
  assign w_lives_mode  = (r_mode == 4'b0010);
  assign w_timed_mode  = (r_mode == 4'b0100);
  assign w_cont_mode   = (r_mode == 4'b0001);
  assign w_rounds_mode = !(w_lives_mode || w_timed_mode);

  assign w_light_rise = light_valid && !r_light_prev;
  assign w_time_up    = w_timed_mode && (time_left == 6'd0) &&
                        (r_state inside {S_WAIT_LIGHT, S_ARMED, S_HIT, S_MISSED});

  assign w_score_inc  = (r_score  == {CW{1'b1}}) ? r_score  : r_score  + 1'b1;
  assign w_misses_inc = (r_misses == {CW{1'b1}}) ? r_misses : r_misses + 1'b1;
  assign w_rounds_inc = (r_rounds == {CW{1'b1}}) ? r_rounds : r_rounds + 1'b1;
  assign w_lives_dec  = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;

  // Judged at round completion; lives were already updated when the miss was taken.
  assign w_end = (w_rounds_mode && (w_rounds_inc >= max_hits)) ||
                 (w_cont_mode && (r_state == S_MISSED)) ||
                 (w_lives_mode && (r_lives == 2'd0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_mode       <= 4'b1000;
      r_target     <= 4'd0;
      r_light_prev <= 1'b0;
      r_score      <= '0;
      r_misses     <= '0;
      r_rounds     <= '0;
      r_lives      <= 2'(MAX_LIVES);
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_light_prev <= light_valid;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      if (r_state != S_IDLE && !start) begin
        r_state     <= S_IDLE;
        r_game_over <= 1'b0;
      end else if (w_time_up) begin
        r_state     <= S_OVER;
        r_game_over <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_score  <= '0;
              r_misses <= '0;
              r_rounds <= '0;
              r_lives  <= 2'(MAX_LIVES);
              r_mode   <= mode;
              r_state  <= S_WAIT_LIGHT;
            end
          end
          S_WAIT_LIGHT: begin
            if (w_light_rise) begin
              r_target <= light_pos;
              r_state  <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (key_valid && key == r_target) begin
              r_score     <= w_score_inc;
              r_hit_pulse <= 1'b1;
              r_state     <= S_HIT;
            end else if (key_valid || !light_valid) begin
              r_misses     <= w_misses_inc;
              r_miss_pulse <= 1'b1;
              if (w_lives_mode) r_lives <= w_lives_dec;
              r_state <= S_MISSED;
            end
          end
          S_HIT, S_MISSED: begin
            if (!light_valid) begin
              r_rounds <= w_rounds_inc;
              if (w_end) begin
                r_state     <= S_OVER;
                r_game_over <= 1'b1;
              end else begin
                r_state <= S_WAIT_LIGHT;
              end
            end
          end
          S_OVER: r_game_over <= 1'b1;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign score      = r_score;
  assign misses     = r_misses;
  assign rounds     = r_rounds;
  assign lives_left = r_lives;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_round_judge.sv
// tb/tb_round_judge.sv - directed self-checking bench for round_judge
module tb_round_judge;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] mode;
  logic [5:0] max_hits;
  logic [5:0] time_left;
  logic       light_valid;
  logic [3:0] light_pos;
  logic       key_valid;
  logic [3:0] key;
  logic [5:0] score, misses, rounds;
  logic [1:0] lives_left;
  logic       hit_pulse, miss_pulse, game_over;

  int total = 0;
  int bad   = 0;

  round_judge #(.MAX_LIVES(3), .CW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .max_hits(max_hits),
    .time_left(time_left), .light_valid(light_valid), .light_pos(light_pos),
    .key_valid(key_valid), .key(key), .score(score), .misses(misses),
    .rounds(rounds), .lives_left(lives_left), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_game(input logic [3:0] m, input logic [5:0] mh);
    start = 1'b0;
    tick();
    mode     = m;
    max_hits = mh;
    start    = 1'b1;
    tick();
  endtask

  task automatic light_on(input logic [3:0] pos);
    light_valid = 1'b1;
    light_pos   = pos;
    tick();
  endtask

  task automatic light_off();
    light_valid = 1'b0;
    tick();
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key       = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    total++; if (score !== 6'd0 || misses !== 6'd0 || rounds !== 6'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", score, misses, rounds);
    end
    total++; if (lives_left !== 2'd3) begin
      bad++; $display("FAIL reset_lives got=%0d exp=3", lives_left);
    end
    total++; if ({hit_pulse, miss_pulse, game_over} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {hit_pulse, miss_pulse, game_over});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    begin_game(4'b1000, 6'd3);
    for (int i = 0; i < 3; i++) begin
      light_on(4'(i));
      press(4'(i));
      total++; if (score !== 6'(i + 1) || hit_pulse !== 1'b1) begin
        bad++; $display("FAIL normal_hit%0d score=%0d pulse=%b exp=%0d/1", i, score, hit_pulse, i + 1);
      end
      tick();
      total++; if (hit_pulse !== 1'b0) begin
        bad++; $display("FAIL normal_pulse_width%0d got=%b exp=0", i, hit_pulse);
      end
      light_off();
      total++; if (rounds !== 6'(i + 1) || game_over !== (i == 2)) begin
        bad++; $display("FAIL normal_round%0d rounds=%0d over=%b exp=%0d/%0d", i, rounds, game_over, i + 1, (i == 2));
      end
    end
    light_on(4'd2);
    press(4'd2);
    tick();
    total++; if (score !== 6'd3 || misses !== 6'd0 || game_over !== 1'b1) begin
      bad++; $display("FAIL normal_after_over score=%0d misses=%0d over=%b exp=3/0/1", score, misses, game_over);
    end
    light_off();
  endtask

  task automatic test_wrong_then_right();
    begin_game(4'b1000, 6'd5);
    light_on(4'd4);
    press(4'd2);
    total++; if (misses !== 6'd1 || score !== 6'd0 || miss_pulse !== 1'b1) begin
      bad++; $display("FAIL wrong_key misses=%0d score=%0d pulse=%b exp=1/0/1", misses, score, miss_pulse);
    end
    press(4'd4);
    total++; if (misses !== 6'd1 || score !== 6'd0 || miss_pulse !== 1'b0 || hit_pulse !== 1'b0) begin
      bad++; $display("FAIL second_key_ignored misses=%0d score=%0d mp=%b hp=%b exp=1/0/0/0", misses, score, miss_pulse, hit_pulse);
    end
    light_off();
    total++; if (rounds !== 6'd1 || game_over !== 1'b0) begin
      bad++; $display("FAIL wrong_round rounds=%0d over=%b exp=1/0", rounds, game_over);
    end
  endtask

  task automatic test_lives();
    begin_game(4'b0010, 6'd0);
    for (int i = 0; i < 3; i++) begin
      light_on(4'(i + 3));
      tick();
      light_off();
      total++; if (lives_left !== 2'(2 - i) || miss_pulse !== 1'b1 || misses !== 6'(i + 1)) begin
        bad++; $display("FAIL lives_miss%0d lives=%0d pulse=%b misses=%0d exp=%0d/1/%0d", i, lives_left, miss_pulse, misses, 2 - i, i + 1);
      end
      tick();
      total++; if (rounds !== 6'(i + 1) || game_over !== (i == 2)) begin
        bad++; $display("FAIL lives_round%0d rounds=%0d over=%b exp=%0d/%0d", i, rounds, game_over, i + 1, (i == 2));
      end
    end
  endtask

  task automatic test_timed();
    begin_game(4'b0100, 6'd0);
    light_on(4'd5);
    time_left = 6'd0;
    tick();
    total++; if (game_over !== 1'b1 || rounds !== 6'd0 || miss_pulse !== 1'b0) begin
      bad++; $display("FAIL timed_end over=%b rounds=%0d mp=%b exp=1/0/0", game_over, rounds, miss_pulse);
    end
    light_off();
    total++; if (misses !== 6'd0 || rounds !== 6'd0 || game_over !== 1'b1) begin
      bad++; $display("FAIL timed_frozen misses=%0d rounds=%0d over=%b exp=0/0/1", misses, rounds, game_over);
    end
    time_left = 6'd60;
  endtask

  task automatic test_continuity();
    begin_game(4'b0001, 6'd5);
    light_on(4'd0);
    press(4'd1);
    light_off();
    total++; if (rounds !== 6'd1 || game_over !== 1'b1) begin
      bad++; $display("FAIL continuity_end rounds=%0d over=%b exp=1/1", rounds, game_over);
    end
  endtask

  task automatic test_start_with_light_on();
    start = 1'b0;
    tick();
    light_valid = 1'b1;
    light_pos   = 4'd6;
    tick();
    mode     = 4'b1000;
    max_hits = 6'd5;
    start    = 1'b1;
    tick();
    press(4'd6);
    total++; if (score !== 6'd0 || hit_pulse !== 1'b0 || misses !== 6'd0) begin
      bad++; $display("FAIL stale_light score=%0d hp=%b misses=%0d exp=0/0/0", score, hit_pulse, misses);
    end
    light_off();
    light_on(4'd3);
    press(4'd3);
    total++; if (score !== 6'd1) begin
      bad++; $display("FAIL next_light_armed score=%0d exp=1", score);
    end
    light_off();
  endtask

  task automatic test_key_on_fall();
    begin_game(4'b1000, 6'd5);
    light_on(4'd7);
    key_valid   = 1'b1;
    key         = 4'd7;
    light_valid = 1'b0;
    tick();
    key_valid = 1'b0;
    total++; if (score !== 6'd1 || hit_pulse !== 1'b1 || misses !== 6'd0) begin
      bad++; $display("FAIL key_on_fall score=%0d hp=%b misses=%0d exp=1/1/0", score, hit_pulse, misses);
    end
    tick();
    total++; if (rounds !== 6'd1 || misses !== 6'd0) begin
      bad++; $display("FAIL key_on_fall_round rounds=%0d misses=%0d exp=1/0", rounds, misses);
    end
  endtask

  task automatic test_reset_mid_armed();
    begin_game(4'b0010, 6'd5);
    light_on(4'd1);
    press(4'd2);
    light_off();
    light_on(4'd2);
    #2;
    reset = 1'b0;
    #1;
    total++; if (score !== 6'd0 || misses !== 6'd0 || rounds !== 6'd0 || lives_left !== 2'd3) begin
      bad++; $display("FAIL async_reset s=%0d m=%0d r=%0d l=%0d exp=0/0/0/3", score, misses, rounds, lives_left);
    end
    total++; if ({hit_pulse, miss_pulse, game_over} !== 3'b000) begin
      bad++; $display("FAIL async_reset_flags got=%b exp=000", {hit_pulse, miss_pulse, game_over});
    end
    tick();
    reset = 1'b1;
    light_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    mode        = 4'b1000;
    max_hits    = 6'd3;
    time_left   = 6'd60;
    light_valid = 1'b0;
    light_pos   = 4'd0;
    key_valid   = 1'b0;
    key         = 4'd0;
    test_reset();
    test_normal();
    test_wrong_then_right();
    test_lives();
    test_timed();
    test_continuity();
    test_start_with_light_on();
    test_key_on_fall();
    test_reset_mid_armed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
